cv32e40p_tmr_scrub_ctrl: RTL and testbench

Sequential consumer of the TMR voter result: data replicas, voted value and tmr_err.
- Detects which replica disagrees with the vote.
- Rewrites all three replicas with the voted value (scrub).
- Re-checks the result after a settle time and escalates persistent or uncorrectable disagreement to a sticky fault.
- Sits downstream of each voted register group, e.g. PC or CSR triplication; fault_o feeds the core's halt/debug request logic.

---
 rtl/cv32e40p_tmr_scrub_ctrl_pkg.sv | 17 +
 rtl/cv32e40p_tmr_scrub_ctrl_mismatch.sv | 26 ++
 rtl/cv32e40p_tmr_scrub_ctrl.sv | 141 ++++++++++++++
 tb/tb_cv32e40p_tmr_scrub_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_tmr_scrub_ctrl_pkg.sv
// ==== cv32e40p_pkg : shared TMR scrub types and constants ==== rev 1.0 ====
`default_nettype none

package cv32e40p_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCRUB  = 2'd1,
    SETTLE = 2'd2,
    FAULT  = 2'd3
  } scrub_state_e;

  localparam int TMR_REPLICAS = 3;

endpackage

`default_nettype wire

// File: rtl/cv32e40p_tmr_scrub_ctrl_mismatch.sv
// ==== cv32e40p_tmr_mismatch : per-replica disagreement decode ==== rev 1.0 ====
`default_nettype none

module cv32e40p_tmr_mismatch
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   data_0,
  input  logic [DATA_WIDTH-1:0]   data_1,
  input  logic [DATA_WIDTH-1:0]   data_2,
  input  logic [DATA_WIDTH-1:0]   voted,
  output logic [TMR_REPLICAS-1:0] mis,
  output logic                    uncorr
);

  assign mis[0] = (data_0 != voted);
  assign mis[1] = (data_1 != voted);
  assign mis[2] = (data_2 != voted);

  // No two replicas agree, so no majority exists to scrub with.
  assign uncorr = (data_0 != data_1) && (data_1 != data_2) && (data_0 != data_2);

endmodule

`default_nettype wire

// File: rtl/cv32e40p_tmr_scrub_ctrl.sv
// ==== cv32e40p_tmr_scrub_ctrl : scrub/re-check/escalate controller ==== rev 1.0 ====
`default_nettype none

module cv32e40p_tmr_scrub_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned MAX_RETRY     = 2,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_0_i,
  input  logic [DATA_WIDTH-1:0] data_1_i,
  input  logic [DATA_WIDTH-1:0] data_2_i,
  input  logic [DATA_WIDTH-1:0] voted_i,
  input  logic                  tmr_err_i,
  input  logic                  clear_i,
  output logic                  scrub_we_o,
  output logic [DATA_WIDTH-1:0] scrub_data_o,
  output logic                  busy_o,
  output logic                  fault_o,
  output logic [2:0]            err_mask_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

  scrub_state_e          state_q, state_d;
  logic [2:0]            retry_q, retry_d;
  logic [3:0]            settle_q, settle_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]            mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  fault_q, fault_d;
  logic                  busy_q, busy_d;
  logic [TMR_REPLICAS-1:0] mis;
  logic                  uncorr;

  cv32e40p_tmr_mismatch #(.DATA_WIDTH(DATA_WIDTH)) u_mismatch (
    .data_0 (data_0_i),
    .data_1 (data_1_i),
    .data_2 (data_2_i),
    .voted  (voted_i),
    .mis    (mis),
    .uncorr (uncorr)
  );

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    settle_d = settle_q;
    data_d   = data_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          cnt_d  = '0;
          mask_d = '0;
        end else if (tmr_err_i && uncorr) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (tmr_err_i) begin
          data_d  = voted_i;
          mask_d  = mask_q | mis;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
          retry_d = '0;
          state_d = SCRUB;
        end
      end
      SCRUB: begin
        settle_d = SETTLE_INIT;
        state_d  = SETTLE;
      end
      SETTLE: begin
        // Only the final settle cycle samples the voter; earlier drops are ignored.
        if (settle_q > 4'd1) begin
          settle_d = settle_q - 4'd1;
        end else begin
          settle_d = '0;
          if (!tmr_err_i) begin
            state_d = IDLE;
          end else if (uncorr || ((retry_q + 3'd1) == RETRY_LIMIT)) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            retry_d = retry_q + 3'd1;
            mask_d  = mask_q | mis;
            state_d = SCRUB;
          end
        end
      end
      FAULT: begin
        if (clear_i) begin
          state_d = IDLE;
          mask_d  = '0;
          cnt_d   = '0;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCRUB) || (state_d == SETTLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      retry_q  <= '0;
      settle_q <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      settle_q <= settle_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      busy_q   <= busy_d;
    end
  end

  assign scrub_we_o   = (state_q == SCRUB);
  assign scrub_data_o = data_q;
  assign busy_o       = busy_q;
  assign fault_o      = fault_q;
  assign err_mask_o   = mask_q;
  assign err_cnt_o    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_tmr_scrub_ctrl.sv
// ==== tb_cv32e40p_tmr_scrub_ctrl : directed bench with replica write-back model ==== rev 1.0 ====
`default_nettype none

module tb_cv32e40p_tmr_scrub_ctrl;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] r0 = '0, r1 = '0, r2 = '0;
  logic          stuck2 = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] voted;
  logic          tmr_err;
  logic          scrub_we, busy, fault;
  logic [DW-1:0] scrub_data;
  logic [2:0]    err_mask;
  logic [CW-1:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int p0;

  assign voted   = (r0 & r1) | (r1 & r2) | (r0 & r2);
  assign tmr_err = !((r0 == r1) && (r1 == r2));

  always #5 clk = ~clk;

  cv32e40p_tmr_scrub_ctrl #(
    .DATA_WIDTH(DW), .SETTLE_CYCLES(1), .MAX_RETRY(2), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .data_0_i(r0), .data_1_i(r1), .data_2_i(r2),
    .voted_i(voted), .tmr_err_i(tmr_err), .clear_i(clear),
    .scrub_we_o(scrub_we), .scrub_data_o(scrub_data),
    .busy_o(busy), .fault_o(fault), .err_mask_o(err_mask), .err_cnt_o(err_cnt)
  );

  // Replica registers take the scrub value when the write enable is seen.
  task automatic tick();
    @(negedge clk);
    if (scrub_we) begin
      pulses++;
      r0 = scrub_data;
      r1 = scrub_data;
      if (!stuck2) r2 = scrub_data;
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_all(input logic [DW-1:0] v);
    r0 = v; r1 = v; r2 = v;
  endtask

  task automatic test_reset();
    set_all(32'h1234_5678);
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    tests++; if (fault !== 1'b0 || busy !== 1'b0 || err_mask !== 3'b000) begin
      fails++; $display("FAIL reset_flags fault=%b busy=%b mask=%b expected 0/0/000", fault, busy, err_mask); end
    tests++; if (err_cnt !== 2'd0 || scrub_data !== 32'h0) begin
      fails++; $display("FAIL reset_regs cnt=%0d data=%h expected 0/0", err_cnt, scrub_data); end
    p0 = pulses;
    ticks(20);
    tests++; if (pulses !== p0 || busy !== 1'b0 || fault !== 1'b0 || err_cnt !== 2'd0) begin
      fails++; $display("FAIL quiet_idle pulses=%0d busy=%b fault=%b cnt=%0d expected 0/0/0/0", pulses - p0, busy, fault, err_cnt); end
  endtask

  task automatic test_single_correct();
    set_all(32'hA5A5_A5A5);
    r1 = 32'hDEAD_BEEF;
    p0 = pulses;
    tick();
    tests++; if (scrub_we !== 1'b1 || scrub_data !== 32'hA5A5_A5A5) begin
      fails++; $display("FAIL scrub_pulse we=%b data=%h expected 1/a5a5a5a5", scrub_we, scrub_data); end
    tests++; if (err_mask !== 3'b010 || err_cnt !== 2'd1 || busy !== 1'b1) begin
      fails++; $display("FAIL single_state mask=%b cnt=%0d busy=%b expected 010/1/1", err_mask, err_cnt, busy); end
    tick();
    tests++; if (scrub_we !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL settle_cycle we=%b busy=%b expected 0/1", scrub_we, busy); end
    tick();
    tests++; if (busy !== 1'b0 || fault !== 1'b0 || pulses - p0 !== 1) begin
      fails++; $display("FAIL back_to_idle busy=%b fault=%b pulses=%0d expected 0/0/1", busy, fault, pulses - p0); end
  endtask

  task automatic test_retry_fault();
    clear = 1'b1; tick(); clear = 1'b0;
    r0 = 32'hCAFE_0001; r1 = 32'hCAFE_0001; r2 = 32'h0; stuck2 = 1'b1;
    p0 = pulses;
    ticks(10);
    tests++; if (pulses - p0 !== 2 || fault !== 1'b1) begin
      fails++; $display("FAIL retry_exhaust pulses=%0d fault=%b expected 2/1", pulses - p0, fault); end
    tests++; if (err_mask !== 3'b100 || err_cnt !== 2'd1 || busy !== 1'b0) begin
      fails++; $display("FAIL retry_state mask=%b cnt=%0d busy=%b expected 100/1/0", err_mask, err_cnt, busy); end
    ticks(10);
    tests++; if (pulses - p0 !== 2 || fault !== 1'b1) begin
      fails++; $display("FAIL fault_sticky pulses=%0d fault=%b expected 2/1", pulses - p0, fault); end
  endtask

  task automatic test_uncorrectable();
    stuck2 = 1'b0;
    set_all(32'h0000_0077);
    clear = 1'b1; tick(); clear = 1'b0;
    tests++; if (fault !== 1'b0 || err_mask !== 3'b000 || err_cnt !== 2'd0) begin
      fails++; $display("FAIL clear_fault fault=%b mask=%b cnt=%0d expected 0/000/0", fault, err_mask, err_cnt); end
    r0 = 32'h0000_0011;
    ticks(4);
    tests++; if (err_cnt !== 2'd1 || err_mask !== 3'b001 || busy !== 1'b0) begin
      fails++; $display("FAIL pre_uncorr cnt=%0d mask=%b busy=%b expected 1/001/0", err_cnt, err_mask, busy); end
    r0 = 32'h1; r1 = 32'h2; r2 = 32'h3;
    p0 = pulses;
    tick();
    tests++; if (fault !== 1'b1 || busy !== 1'b0 || pulses !== p0 || err_cnt !== 2'd1) begin
      fails++; $display("FAIL uncorr_fault fault=%b busy=%b pulses=%0d cnt=%0d expected 1/0/0/1", fault, busy, pulses - p0, err_cnt); end
    set_all(32'h0000_0007);
    clear = 1'b1; tick(); clear = 1'b0;
    tests++; if (fault !== 1'b0 || err_mask !== 3'b000 || err_cnt !== 2'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL uncorr_clear fault=%b mask=%b cnt=%0d busy=%b expected 0/000/0/0", fault, err_mask, err_cnt, busy); end
    tests++; if (scrub_data !== 32'h0000_0077) begin
      fails++; $display("FAIL data_hold data=%h expected 00000077", scrub_data); end
  endtask

  task automatic test_cnt_saturate();
    p0 = pulses;
    for (int k = 0; k < 5; k++) begin
      r2 = 32'h0BAD_0000 + DW'(k);
      ticks(4);
      if (k == 2) begin
        tests++; if (err_cnt !== 2'd3) begin
          fails++; $display("FAIL cnt_three cnt=%0d expected 3", err_cnt); end
      end
    end
    tests++; if (err_cnt !== 2'd3 || err_mask !== 3'b100) begin
      fails++; $display("FAIL cnt_saturate cnt=%0d mask=%b expected 3/100", err_cnt, err_mask); end
    tests++; if (pulses - p0 !== 5 || fault !== 1'b0) begin
      fails++; $display("FAIL five_events pulses=%0d fault=%b expected 5/0", pulses - p0, fault); end
  endtask

  task automatic test_async_reset();
    r1 = 32'hFFFF_0000;
    tick();
    tick();
    tests++; if (busy !== 1'b1 || scrub_we !== 1'b0) begin
      fails++; $display("FAIL in_settle busy=%b we=%b expected 1/0", busy, scrub_we); end
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || fault !== 1'b0 || err_mask !== 3'b000 || err_cnt !== 2'd0 || scrub_data !== 32'h0 || scrub_we !== 1'b0) begin
      fails++; $display("FAIL async_reset busy=%b fault=%b mask=%b cnt=%0d data=%h we=%b expected all 0", busy, fault, err_mask, err_cnt, scrub_data, scrub_we); end
    tick();
    rst = 1'b0;
    p0 = pulses;
    ticks(3);
    tests++; if (busy !== 1'b0 || fault !== 1'b0 || pulses !== p0 || err_cnt !== 2'd0) begin
      fails++; $display("FAIL post_reset busy=%b fault=%b pulses=%0d cnt=%0d expected 0/0/0/0", busy, fault, pulses - p0, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_correct();
    test_retry_fault();
    test_uncorrectable();
    test_cnt_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
